// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the requesters/clear control and the register file.
interface regfile_wr_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic              Reg_Write;
    logic [ADDR_W-1:0] W_Addr;
    logic [DATA_W-1:0] W_Data;

    // Requester / clear-control side.
    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output clr_start,
        input  req0_ready, req1_ready, clr_busy, clr_done,
        input  Reg_Write, W_Addr, W_Data
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  clr_start,
        output req0_ready, req1_ready, clr_busy, clr_done,
        output Reg_Write, W_Addr, W_Data
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter for the general register file, with a
// sequenced clear that zeroes registers 1..NREG-1 through the same port.
module regfile_wr_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input logic                  clk_Regs,
    input logic                  rst,
    regfile_wr_arbiter_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic              rr;
    logic [ADDR_W-1:0] clr_cnt;
    logic              grant0;
    logic              grant1;

    // Ready decode: clear request wins, single requester wins, ties go to rr.
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        if (state == SERVE && !bus.clr_start) begin
            if (bus.req0_valid && !bus.req1_valid) begin
                bus.req0_ready = 1'b1;
            end else if (bus.req1_valid && !bus.req0_valid) begin
                bus.req1_ready = 1'b1;
            end else if (bus.req0_valid && bus.req1_valid) begin
                bus.req0_ready = !rr;
                bus.req1_ready = rr;
            end
        end
    end

    assign grant0       = bus.req0_valid && bus.req0_ready;
    assign grant1       = bus.req1_valid && bus.req1_ready;
    assign bus.clr_busy = (state == CLEAR);

    // State, round-robin pointer, clear counter and registered write port.
    always_ff @(posedge clk_Regs) begin
        if (rst) begin
            state         <= SERVE;
            rr            <= 1'b0;
            clr_cnt       <= FIRST_ADDR;
            bus.Reg_Write <= 1'b0;
            bus.W_Addr    <= '0;
            bus.W_Data    <= '0;
            bus.clr_done  <= 1'b0;
        end else begin
            bus.Reg_Write <= 1'b0;
            bus.clr_done  <= 1'b0;
            case (state)
                SERVE: begin
                    if (bus.clr_start) begin
                        state   <= CLEAR;
                        clr_cnt <= FIRST_ADDR;
                    end else if (grant0) begin
                        bus.W_Addr    <= bus.req0_addr;
                        bus.W_Data    <= bus.req0_data;
                        bus.Reg_Write <= (bus.req0_addr != '0);
                        rr            <= 1'b1;
                    end else if (grant1) begin
                        bus.W_Addr    <= bus.req1_addr;
                        bus.W_Data    <= bus.req1_data;
                        bus.Reg_Write <= (bus.req1_addr != '0);
                        rr            <= 1'b0;
                    end
                end
                CLEAR: begin
                    bus.Reg_Write <= 1'b1;
                    bus.W_Addr    <= clr_cnt;
                    bus.W_Data    <= '0;
                    if (clr_cnt == LAST_ADDR) begin
                        bus.clr_done <= 1'b1;
                        state        <= SERVE;
                        clr_cnt      <= FIRST_ADDR;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: state <= SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a simple register-file model.
module tb_regfile_wr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] rf [32];

    regfile_wr_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_wr_arbiter #(.ADDR_W(5), .DATA_W(32), .NREG(32)) dut (
        .clk_Regs (clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // Register file model: commits on the edge after Reg_Write is presented.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'hA500_0000 | 32'(i);
        end else if (bus.Reg_Write) begin
            rf[bus.W_Addr] <= bus.W_Data;
        end
    end

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.clr_start  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.Reg_Write !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.Reg_Write); end
        checks++; if (bus.W_Addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.W_Addr); end
        checks++; if (bus.W_Data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.W_Data); end
        checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.clr_done); end
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.clr_busy); end
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL reset_rr: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'hDEAD_BEEF;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        idle_inputs();
        checks++; if (bus.Reg_Write !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", bus.Reg_Write); end
        checks++; if (bus.W_Addr !== 5'd5) begin errors++; $display("FAIL single_addr: got %0d want 5", bus.W_Addr); end
        checks++; if (bus.W_Data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", bus.W_Data); end
        @(negedge clk);
        checks++; if (bus.Reg_Write !== 1'b0) begin errors++; $display("FAIL single_we_off: got %b want 0", bus.Reg_Write); end
        checks++; if (bus.W_Addr !== 5'd5) begin errors++; $display("FAIL single_hold: got %0d want 5", bus.W_Addr); end
    endtask

    // Runs after test_single_write, so rr points at requester 1 here.
    task automatic test_addr_zero();
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", bus.req1_ready); end
        @(negedge clk);
        idle_inputs();
        checks++; if (bus.Reg_Write !== 1'b0) begin errors++; $display("FAIL zero_we: got %b want 0", bus.Reg_Write); end
        checks++; if (bus.W_Addr !== 5'd0) begin errors++; $display("FAIL zero_addr: got %0d want 0", bus.W_Addr); end
        checks++; if (bus.W_Data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL zero_data: got %h want ffffffff", bus.W_Data); end
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h33;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'h44;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL zero_rr: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        idle_inputs();
        checks++; if ({bus.Reg_Write, bus.W_Addr} !== {1'b1, 5'd3}) begin errors++; $display("FAIL zero_next_write: got %b/%0d want 1/3", bus.Reg_Write, bus.W_Addr); end
    endtask

    task automatic test_contention();
        logic [4:0]  ea;
        logic [31:0] ed;
        apply_reset();
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                ea = ((i - 1) % 2 == 0) ? 5'd1 : 5'd2;
                ed = ((i - 1) % 2 == 0) ? 32'h11 : 32'h22;
                checks++; if ({bus.Reg_Write, bus.W_Addr, bus.W_Data} !== {1'b1, ea, ed}) begin errors++; $display("FAIL cont_write%0d: got %b/%0d/%h want 1/%0d/%h", i, bus.Reg_Write, bus.W_Addr, bus.W_Data, ea, ed); end
            end
            if (i < 4) begin
                bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h11;
                bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h22;
                #1;
                checks++; if ({bus.req0_ready, bus.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_grant%0d: got %b want %b", i, {bus.req0_ready, bus.req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
                @(negedge clk);
            end else begin
                idle_inputs();
            end
        end
        @(negedge clk);
        checks++; if (bus.Reg_Write !== 1'b0) begin errors++; $display("FAIL cont_end: got %b want 0", bus.Reg_Write); end
    endtask

    task automatic test_clear_sweep();
        int busy_cycles;
        busy_cycles = 0;
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0;
        bus.clr_start = 1'b1;
        @(negedge clk);
        bus.clr_start = 1'b0;
        if (bus.clr_busy === 1'b1) busy_cycles++;
        checks++; if (bus.Reg_Write !== 1'b0) begin errors++; $display("FAIL clr_first_idle: got %b want 0", bus.Reg_Write); end
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            if (bus.clr_busy === 1'b1) busy_cycles++;
            checks++;
            if ({bus.Reg_Write, bus.W_Addr, bus.W_Data, bus.clr_done} !== {1'b1, 5'(k), 32'd0, (k == 31)}) begin
                errors++; $display("FAIL clr_write%0d: got we=%b addr=%0d data=%h done=%b", k, bus.Reg_Write, bus.W_Addr, bus.W_Data, bus.clr_done);
            end
        end
        checks++; if (busy_cycles !== 31) begin errors++; $display("FAIL clr_busy_len: got %0d want 31", busy_cycles); end
        @(negedge clk);
        checks++; if ({bus.Reg_Write, bus.clr_busy, bus.clr_done} !== 3'b000) begin errors++; $display("FAIL clr_after: got %b want 000", {bus.Reg_Write, bus.clr_busy, bus.clr_done}); end
        for (int r = 1; r < 32; r++) begin
            checks++; if (rf[r] !== 32'd0) begin errors++; $display("FAIL clr_readback%0d: got %h want 0", r, rf[r]); end
        end
        checks++; if (rf[0] !== 32'hA500_0000) begin errors++; $display("FAIL clr_r0_untouched: got %h want a5000000", rf[0]); end
    endtask

    task automatic test_clear_vs_request();
        @(negedge clk);
        bus.clr_start = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h77;
        #1;
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL cvr_start_ready: got %b want 0", bus.req0_ready); end
        @(negedge clk);
        bus.clr_start = 1'b0;
        #1;
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL cvr_ready0: got %b want 0", bus.req0_ready); end
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus.clr_done, bus.req0_ready} !== ((k == 31) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL cvr_cycle%0d: got done/ready=%b want %b", k, {bus.clr_done, bus.req0_ready}, (k == 31) ? 2'b11 : 2'b00);
            end
        end
        @(negedge clk);
        idle_inputs();
        checks++; if ({bus.Reg_Write, bus.W_Addr, bus.W_Data} !== {1'b1, 5'd7, 32'h77}) begin errors++; $display("FAIL cvr_write: got %b/%0d/%h want 1/7/77", bus.Reg_Write, bus.W_Addr, bus.W_Data); end
    endtask

    task automatic test_reset_mid_clear();
        bit found;
        int late_writes;
        found = 1'b0;
        late_writes = 0;
        @(negedge clk); bus.clr_start = 1'b1;
        @(negedge clk); bus.clr_start = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (bus.Reg_Write === 1'b1 && bus.W_Addr === 5'd10) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_reach10: got timeout want W_Addr=10"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({bus.Reg_Write, bus.clr_busy, bus.clr_done} !== 3'b000) begin errors++; $display("FAIL mid_reset: got %b want 000", {bus.Reg_Write, bus.clr_busy, bus.clr_done}); end
        for (int n = 0; n < 35; n++) begin
            @(negedge clk);
            if (bus.Reg_Write === 1'b1) late_writes++;
        end
        checks++; if (late_writes !== 0) begin errors++; $display("FAIL mid_no_writes: got %0d want 0", late_writes); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_addr_zero();
        test_contention();
        test_clear_sweep();
        test_clear_vs_request();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
